// File: rtl/vector_load_unit.sv
// vector_load_unit: strided vector load sequencer. Fetches VEC_SIZE 32-bit words
// one at a time over a valid/ready memory port (single outstanding request),
// assembles them in a buffer and writes the whole vector to the vector RF in one cycle.
// Optional feature macro: VLOAD_ERR_EN adds mem_rsp_err input and err output;
// an error response aborts the command (no RF write, done+err pulse).
module vector_load_unit #(
  parameter int unsigned VEC_SIZE = 8,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_vd,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_stride,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
`ifdef VLOAD_ERR_EN
  input  logic              mem_rsp_err,
  output logic              err,
`endif
  output logic              vrf_we,
  output logic [4:0]        vrf_waddr,
  output logic [31:0]       vrf_wvec [VEC_SIZE-1:0],
  output logic              done
);

  localparam int unsigned IDX_W = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [REG_W-1:0]    vd_q;
  logic [ADDR_W-1:0]   stride_q;
  logic                rsp_bad;

  // Error qualifier for a returned word; constant good when the error path is absent
`ifdef VLOAD_ERR_EN
  assign rsp_bad = mem_rsp_err;
`else
  assign rsp_bad = 1'b0;
`endif

  // Sequencer: command capture, request issue, response assembly, RF write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      vd_q          <= '0;
      stride_q      <= '0;
      cmd_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      vrf_we        <= 1'b0;
      vrf_waddr     <= '0;
      done          <= 1'b0;
`ifdef VLOAD_ERR_EN
      err           <= 1'b0;
`endif
      for (int i = 0; i < int'(VEC_SIZE); i++) vrf_wvec[i] <= '0;
    end else begin
      vrf_we <= 1'b0;
      done   <= 1'b0;
`ifdef VLOAD_ERR_EN
      err    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            state         <= S_REQ;
            cmd_ready     <= 1'b0;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= cmd_base;
            vd_q          <= cmd_vd;
            stride_q      <= cmd_stride;
            idx           <= '0;
          end
        end
        S_REQ: begin
          // Address and valid stay put until the memory accepts
          if (mem_req_ready) begin
            state         <= S_WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid && rsp_bad) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            done      <= 1'b1;
`ifdef VLOAD_ERR_EN
            err       <= 1'b1;
`endif
          end else if (mem_rsp_valid) begin
            vrf_wvec[idx] <= mem_rsp_data;
            if (idx == IDX_W'(VEC_SIZE - 1)) begin
              // Writes to v0 are suppressed but the command still completes
              state     <= S_WRITE;
              vrf_we    <= (vd_q != '0);
              vrf_waddr <= vd_q;
              done      <= 1'b1;
            end else begin
              state         <= S_REQ;
              idx           <= idx + IDX_W'(1);
              mem_req_addr  <= mem_req_addr + stride_q;
              mem_req_valid <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_load_unit.sv
// tb_vector_load_unit: directed self-checking bench for vector_load_unit.
// Define VLOAD_ERR_EN for both files to exercise the error-abort path.
module tb_vector_load_unit;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_vd;
  logic [31:0] cmd_base;
  logic [31:0] cmd_stride;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
`ifdef VLOAD_ERR_EN
  logic        mem_rsp_err;
  logic        err;
`endif
  logic        vrf_we;
  logic [4:0]  vrf_waddr;
  logic [31:0] vrf_wvec [7:0];
  logic        done;

  int checks;
  int failures;

  // Observations collected by run_load
  logic [31:0] got_addr [$];
  logic [31:0] vec_at_done [8];
  logic [4:0]  we_addr;
  logic [31:0] stall_addr;
  int  we_cnt, done_cnt, err_cnt, we_cyc, done_cyc, stall_seen;
  bit  stall_addr_ok, ready_after, ready_at_cmd, err_at_done, timeout;

  vector_load_unit #(.VEC_SIZE(8), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_vd        (cmd_vd),
    .cmd_base      (cmd_base),
    .cmd_stride    (cmd_stride),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
`ifdef VLOAD_ERR_EN
    .mem_rsp_err   (mem_rsp_err),
    .err           (err),
`endif
    .vrf_we        (vrf_we),
    .vrf_waddr     (vrf_waddr),
    .vrf_wvec      (vrf_wvec),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one command and act as memory; cycle index 0 is the cycle right after the accepting edge.
  // Response data for the k-th accepted request is data0+k. Stops one cycle after done,
  // or right after max_req requests were granted (max_req>0), or on timeout.
  task automatic run_load(input logic [4:0] vd, input logic [31:0] base, input logic [31:0] stride,
                          input logic [31:0] data0, input int stall_elem, input int stall_n,
                          input int err_elem, input int max_req);
    int  n_req;
    int  stall_left;
    bit  rsp_due;
    got_addr.delete();
    we_cnt = 0; done_cnt = 0; err_cnt = 0; we_cyc = -1; done_cyc = -1; stall_seen = 0;
    stall_addr_ok = 1; ready_after = 0; err_at_done = 0; timeout = 1; we_addr = '0; stall_addr = '0;
    for (int i = 0; i < 8; i++) vec_at_done[i] = '0;
    n_req = 0; stall_left = stall_n; rsp_due = 0;
    @(negedge clk);
    ready_at_cmd = cmd_ready;
    cmd_valid = 1'b1; cmd_vd = vd; cmd_base = base; cmd_stride = stride;
    @(posedge clk);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      mem_rsp_valid = rsp_due;
      mem_rsp_data  = rsp_due ? data0 + 32'(n_req - 1) : 32'h0;
`ifdef VLOAD_ERR_EN
      mem_rsp_err   = rsp_due && ((n_req - 1) == err_elem);
`endif
      rsp_due = 0;
      if (vrf_we === 1'b1) begin we_cnt++; we_cyc = c; we_addr = vrf_waddr; end
`ifdef VLOAD_ERR_EN
      if (err === 1'b1) err_cnt++;
`endif
      if (done === 1'b1) begin
        done_cnt++; done_cyc = c;
        for (int i = 0; i < 8; i++) vec_at_done[i] = vrf_wvec[i];
`ifdef VLOAD_ERR_EN
        err_at_done = err;
`endif
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        ready_after = cmd_ready;
        timeout = 0;
        break;
      end
      if (mem_req_valid === 1'b1) begin
        if (n_req == stall_elem && stall_left > 0) begin
          mem_req_ready = 1'b0;
          if (stall_seen == 0) stall_addr = mem_req_addr;
          else if (mem_req_addr !== stall_addr) stall_addr_ok = 0;
          stall_seen++; stall_left--;
        end else begin
          mem_req_ready = 1'b1;
          got_addr.push_back(mem_req_addr);
          n_req++;
          rsp_due = 1;
        end
      end else begin
        mem_req_ready = 1'b0;
      end
      if (max_req > 0 && n_req == max_req) begin
        timeout = 0;
        return;
      end
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
`ifdef VLOAD_ERR_EN
    mem_rsp_err = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
    checks++; if (mem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr got=%h exp=0", mem_req_addr); end
    checks++; if (vrf_we !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_we_done got=%b%b exp=00", vrf_we, done); end
    checks++; if (vrf_waddr !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", vrf_waddr); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (vrf_wvec[i] !== 32'h0) begin failures++; $display("FAIL reset_wvec[%0d] got=%h exp=0", i, vrf_wvec[i]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_load(5'd3, 32'h100, 32'd4, 32'hA0, -1, 0, -1, 0);
    checks++; if (timeout) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++; if (ready_at_cmd !== 1'b1) begin failures++; $display("FAIL basic_ready_idle got=%b exp=1", ready_at_cmd); end
    checks++; if (got_addr.size() != 8) begin failures++; $display("FAIL basic_req_count got=%0d exp=8", got_addr.size()); end
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, got_addr[i], 32'h100 + 32'(4 * i)); end
    end
    // 17th cycle after the accepting edge is index 16
    checks++; if (we_cyc != 16) begin failures++; $display("FAIL basic_latency got=%0d exp=16", we_cyc); end
    checks++; if (we_cnt != 1) begin failures++; $display("FAIL basic_we_pulses got=%0d exp=1", we_cnt); end
    checks++; if (done_cnt != 1 || done_cyc != 16) begin failures++; $display("FAIL basic_done got=%0d@%0d exp=1@16", done_cnt, done_cyc); end
    checks++; if (we_addr !== 5'd3) begin failures++; $display("FAIL basic_waddr got=%0d exp=3", we_addr); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (vec_at_done[i] !== 32'hA0 + 32'(i)) begin failures++; $display("FAIL basic_vec[%0d] got=%h exp=%h", i, vec_at_done[i], 32'hA0 + 32'(i)); end
    end
    checks++; if (ready_after !== 1'b1) begin failures++; $display("FAIL basic_ready_after got=%b exp=1", ready_after); end
  endtask

  task automatic test_stall();
    run_load(5'd3, 32'h100, 32'd4, 32'hB0, 2, 5, -1, 0);
    checks++; if (timeout) begin failures++; $display("FAIL stall_timeout got=1 exp=0"); end
    checks++; if (stall_seen != 5) begin failures++; $display("FAIL stall_valid_held got=%0d exp=5", stall_seen); end
    checks++; if (stall_addr !== 32'h108 || !stall_addr_ok) begin failures++; $display("FAIL stall_addr_held got=%h ok=%b exp=108 ok=1", stall_addr, stall_addr_ok); end
    checks++; if (got_addr.size() != 8 || got_addr[2] !== 32'h108 || got_addr[7] !== 32'h11C) begin failures++; $display("FAIL stall_addrs got_n=%0d exp=8", got_addr.size()); end
    checks++; if (we_cyc != 21 || we_cnt != 1) begin failures++; $display("FAIL stall_latency got=%0d/%0d exp=21/1", we_cyc, we_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (vec_at_done[i] !== 32'hB0 + 32'(i)) begin failures++; $display("FAIL stall_vec[%0d] got=%h exp=%h", i, vec_at_done[i], 32'hB0 + 32'(i)); end
    end
  endtask

  task automatic test_wrap_stride();
    logic [31:0] wrap_exp [8];
    logic [31:0] neg_exp [8];
    wrap_exp = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    neg_exp  = '{32'h40, 32'h30, 32'h20, 32'h10, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFE0, 32'hFFFFFFD0};
    run_load(5'd9, 32'hFFFFFFF8, 32'd4, 32'h11, -1, 0, -1, 0);
    checks++; if (got_addr.size() != 8 || timeout) begin failures++; $display("FAIL wrap_count got=%0d exp=8", got_addr.size()); end
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== wrap_exp[i]) begin failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, got_addr[i], wrap_exp[i]); end
    end
    run_load(5'd10, 32'h200, 32'd0, 32'h50, -1, 0, -1, 0);
    checks++; if (got_addr.size() != 8 || timeout) begin failures++; $display("FAIL stride0_count got=%0d exp=8", got_addr.size()); end
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== 32'h200) begin failures++; $display("FAIL stride0_addr[%0d] got=%h exp=200", i, got_addr[i]); end
    end
    checks++; if (vec_at_done[0] !== 32'h50 || vec_at_done[7] !== 32'h57 || we_addr !== 5'd10) begin failures++; $display("FAIL stride0_vec got=%h,%h exp=50,57", vec_at_done[0], vec_at_done[7]); end
    run_load(5'd11, 32'h40, 32'hFFFFFFF0, 32'h60, -1, 0, -1, 0);
    for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== neg_exp[i]) begin failures++; $display("FAIL negstride_addr[%0d] got=%h exp=%h", i, got_addr[i], neg_exp[i]); end
    end
  endtask

  task automatic test_vd_zero();
    run_load(5'd0, 32'h300, 32'd8, 32'hC0, -1, 0, -1, 0);
    checks++; if (timeout) begin failures++; $display("FAIL vd0_timeout got=1 exp=0"); end
    checks++; if (got_addr.size() != 8) begin failures++; $display("FAIL vd0_req_count got=%0d exp=8", got_addr.size()); end
    checks++; if (we_cnt != 0) begin failures++; $display("FAIL vd0_we got=%0d exp=0", we_cnt); end
    checks++; if (done_cnt != 1 || done_cyc != 16) begin failures++; $display("FAIL vd0_done got=%0d@%0d exp=1@16", done_cnt, done_cyc); end
    checks++; if (vec_at_done[3] !== 32'hC3 || got_addr[7] !== 32'h338) begin failures++; $display("FAIL vd0_data got=%h/%h exp=C3/338", vec_at_done[3], got_addr[7]); end
  endtask

  task automatic test_reset_mid();
    // Grant elements 0..4, then reset while element 4 is outstanding
    run_load(5'd7, 32'h400, 32'd4, 32'hD0, -1, 0, -1, 5);
    checks++; if (timeout) begin failures++; $display("FAIL rstmid_timeout got=1 exp=0"); end
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%b%b exp=10", cmd_ready, mem_req_valid); end
    checks++; if (vrf_wvec[0] !== 32'h0 || vrf_wvec[3] !== 32'h0) begin failures++; $display("FAIL rstmid_buf_clear got=%h,%h exp=0,0", vrf_wvec[0], vrf_wvec[3]); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || done !== 1'b0 || vrf_we !== 1'b0) begin failures++; $display("FAIL rstmid_late_rsp got=%b%b%b exp=100", cmd_ready, done, vrf_we); end
    checks++; if (vrf_wvec[0] !== 32'h0) begin failures++; $display("FAIL rstmid_late_data got=%h exp=0", vrf_wvec[0]); end
    run_load(5'd5, 32'h500, 32'd4, 32'hE0, -1, 0, -1, 0);
    checks++; if (timeout || we_cyc != 16 || we_addr !== 5'd5) begin failures++; $display("FAIL rstmid_next got=%0d@%0d exp=5@16", we_addr, we_cyc); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (vec_at_done[i] !== 32'hE0 + 32'(i)) begin failures++; $display("FAIL rstmid_vec[%0d] got=%h exp=%h", i, vec_at_done[i], 32'hE0 + 32'(i)); end
    end
  endtask

`ifdef VLOAD_ERR_EN
  task automatic test_err();
    run_load(5'd4, 32'h600, 32'd4, 32'hF0, -1, 0, 4, 0);
    checks++; if (timeout) begin failures++; $display("FAIL err_timeout got=1 exp=0"); end
    checks++; if (got_addr.size() != 5) begin failures++; $display("FAIL err_req_count got=%0d exp=5", got_addr.size()); end
    checks++; if (done_cnt != 1 || done_cyc != 10) begin failures++; $display("FAIL err_done got=%0d@%0d exp=1@10", done_cnt, done_cyc); end
    checks++; if (err_at_done !== 1'b1 || err_cnt != 1) begin failures++; $display("FAIL err_flag got=%b/%0d exp=1/1", err_at_done, err_cnt); end
    checks++; if (we_cnt != 0) begin failures++; $display("FAIL err_no_we got=%0d exp=0", we_cnt); end
    checks++; if (ready_after !== 1'b1) begin failures++; $display("FAIL err_ready_after got=%b exp=1", ready_after); end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_vd = '0; cmd_base = '0; cmd_stride = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
`ifdef VLOAD_ERR_EN
    mem_rsp_err = 1'b0;
`endif
    test_reset();
    test_basic();
    test_stall();
    test_wrap_stride();
    test_vd_zero();
    test_reset_mid();
`ifdef VLOAD_ERR_EN
    test_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
